// File: rtl/pic_pkg.sv
// ============================================================================
// Module : pic_pkg
// Brief  : Shared types and constants for the interrupt acknowledge sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pic_pkg;

  localparam int IR_IDX_W             = 3;
  localparam int VEC_BASE_W           = 5;
  localparam int DEFAULT_INTA_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ACK1  = 3'd2,
    WAIT2 = 3'd3,
    VEC   = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/inta_sync.sv
// ============================================================================
// Module : inta_sync
// Brief  : Two-flop synchronizer for INTA_n plus edge register, rise/fall pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inta_sync (
  input  logic clk,
  input  logic rst,
  input  logic inta_n,
  output logic inta_fall,
  output logic inta_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Idle level of INTA_n is high, so all stages reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= inta_n;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign inta_fall = r_prev & ~r_sync;
  assign inta_rise = ~r_prev & r_sync;

endmodule

`default_nettype wire

// File: rtl/inta_sequencer.sv
// ============================================================================
// Module : inta_sequencer
// Brief  : 8259-style two-pulse INTA sequencer; optional auto-EOI via INTA_AEOI_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inta_sequencer
  import pic_pkg::*;
#(
  parameter int INTA_TIMEOUT = DEFAULT_INTA_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  INT_request,
  input  logic [IR_IDX_W-1:0]   serviced_interrupt_index,
  input  logic [VEC_BASE_W-1:0] ICW2_vector_base,
  input  logic                  INTA_n,
  input  logic                  AEOI_mode,
  output logic                  INT,
  output logic                  INT_requestAck,
  output logic                  freezing,
  output logic                  ISR_set_en,
  output logic [IR_IDX_W-1:0]   ISR_set_index,
  output logic                  IRR_clear_en,
  output logic                  ISR_clear_en,
  output logic [IR_IDX_W-1:0]   ISR_clear_index,
  output logic [7:0]            data_out,
  output logic                  data_out_en
);

  localparam int c_cnt_w = ($clog2(INTA_TIMEOUT + 1) > 8) ? $clog2(INTA_TIMEOUT + 1) : 8;
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(INTA_TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  state_t              r_state;
  state_t              w_next;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [IR_IDX_W-1:0] r_index;
  logic                r_spurious;
  logic                r_ack;
  logic                r_seen_rise;
  logic                w_fall;
  logic                w_rise;
  logic                w_timeout;

  inta_sync u_inta_sync (
    .clk       (clk),
    .rst       (rst),
    .inta_n    (INTA_n),
    .inta_fall (w_fall),
    .inta_rise (w_rise)
  );

  assign w_timeout      = (r_cnt == c_timeout);
  assign INT_requestAck = r_ack;

`ifndef INTA_AEOI_EN
  logic w_unused_aeoi;
  assign w_unused_aeoi = AEOI_mode;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_index     <= '0;
      r_spurious  <= 1'b0;
      r_ack       <= 1'b0;
      r_seen_rise <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (!(&r_cnt)) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
      // A request withdrawn before the first INTA is answered with IR7, untracked.
      if (r_state == REQ && w_next == ACK1) begin
        r_spurious <= ~INT_request;
        r_index    <= INT_request ? serviced_interrupt_index : {IR_IDX_W{1'b1}};
        r_ack      <= r_ack ^ INT_request;
      end
      if (w_next == WAIT2 && r_state != WAIT2) begin
        r_seen_rise <= 1'b0;
      end else if (r_state == WAIT2 && w_rise) begin
        r_seen_rise <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    INT             = 1'b0;
    freezing        = 1'b0;
    ISR_set_en      = 1'b0;
    ISR_set_index   = '0;
    IRR_clear_en    = 1'b0;
    ISR_clear_en    = 1'b0;
    ISR_clear_index = '0;
    data_out        = 8'h00;
    data_out_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (INT_request) w_next = REQ;
      end
      REQ: begin
        INT = 1'b1;
        if (w_fall)         w_next = ACK1;
        else if (w_timeout) w_next = IDLE;
      end
      ACK1: begin
        freezing      = 1'b1;
        ISR_set_en    = ~r_spurious;
        IRR_clear_en  = ~r_spurious;
        ISR_set_index = r_spurious ? '0 : r_index;
        w_next        = WAIT2;
      end
      WAIT2: begin
        freezing = 1'b1;
        if (r_seen_rise && w_fall) w_next = VEC;
        else if (w_timeout)        w_next = DONE;
      end
      VEC: begin
        freezing    = 1'b1;
        data_out_en = 1'b1;
        data_out    = {ICW2_vector_base, r_index};
        if (w_rise) w_next = DONE;
      end
      DONE: begin
`ifdef INTA_AEOI_EN
        ISR_clear_en    = AEOI_mode & ~r_spurious;
        ISR_clear_index = (AEOI_mode & ~r_spurious) ? r_index : '0;
`endif
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire
